uart_tx_bridge: RTL

- Transmit side of the board UART interface. It accepts bytes from the processor-side store path and buffers them in a small FIFO.
- It drives txdata/txclk toward the board UART, paced by the txready handshake.
- Sits between the RV32 memory-mapped I/O decode and the top-level txdata/txclk/txready pins. It is the complement of the existing rxdata/rxclk/rxready receive path.

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_fifo.sv | 37 +++
 rtl/uart_tx_bridge.sv | 77 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit/receive types and constants
package uart_pkg;
  localparam int UART_W = 8;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, DRAIN} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO (push/pop/din/dout/full/empty/count), full and empty evaluated pre-pop
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: buffers bytes in a FIFO and strobes them out on txdata/txclk paced by the txready handshake
module uart_tx_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    wr_en,
  input  logic [UART_W-1:0]       wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    clr_ovf,
  output logic [UART_W-1:0]       txdata,
  output logic                    txclk,
  input  logic                    txready
);
  tx_state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0] cnt, cnt_n;
  logic [UART_W-1:0] head;
  logic rdy_s, fifo_empty, pop;
  assign rdy_s = sync[SYNC_STAGES-1];
  assign pop = state == IDLE && !fifo_empty && rdy_s;
  assign empty = fifo_empty && state == IDLE;
  assign txclk = state == STROBE;
  sync_fifo #(.W(UART_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .nrst(nrst),
    .push(wr_en),
    .pop(pop),
    .din(wr_data),
    .dout(head),
    .full(full),
    .empty(fifo_empty),
    .count(count)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE: if (pop) begin
        state_n = SETUP;
        cnt_n = 8'(SETUP_CYCLES);
      end
      SETUP: if (cnt == '0) state_n = STROBE;
             else cnt_n = cnt - 1'b1;
      STROBE: begin
        state_n = ACK;
        cnt_n = 8'(ACK_TIMEOUT - 1);
      end
      ACK: if (!rdy_s) state_n = DRAIN;
           else if (cnt == '0) state_n = IDLE;
           else cnt_n = cnt - 1'b1;
      DRAIN: if (rdy_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      cnt <= '0;
      sync <= '0;
      txdata <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sync <= {sync[SYNC_STAGES-2:0], txready};
      if (pop) txdata <= head;
      overflow <= (wr_en && full) || (overflow && !clr_ovf);
    end
endmodule
